// File: rtl/adder_deser.sv
// adder_deser: serial-to-parallel operand feeder for the adder tree.
// Collects NUM operands of BITS bits over valid/ready into one held group.
//
// Ports:
//   clk, reset      clock, async active-high reset
//   valid, i        upstream operand beat
//   last            short-group terminator (ADDER_DESER_LAST_EN only)
//   ready           upstream may transfer (valid & ready = beat)
//   o               group, slot k at o[k*BITS +: BITS], slot 0 first
//   valid_out       group on o is valid
//   ready_in        downstream accepts (valid_out & ready_in = drain)
//
// Optional build macro: ADDER_DESER_LAST_EN adds the `last` input.
module adder_deser #(
  parameter int BITS = 16,
  parameter int NUM  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [BITS-1:0]     i,
`ifdef ADDER_DESER_LAST_EN
  input  logic                last,
`endif
  output logic                ready,
  output logic [NUM*BITS-1:0] o,
  output logic                valid_out,
  input  logic                ready_in
);

  localparam int CW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(NUM - 1);

  logic [CW-1:0]              cnt;
  logic [NUM-2:0][BITS-1:0]   slot;
  logic [NUM*BITS-1:0]        o_nxt;
  logic                       fin;
  logic                       at_end;
  logic                       acc;
  logic                       done;
  logic                       drain;

`ifdef ADDER_DESER_LAST_EN
  assign fin = valid & last;
`else
  assign fin = 1'b0;
`endif

  // A beat that would complete a group may only enter
  // when the output register is free or draining now.
  assign at_end = (cnt == CNT_MAX) | fin;
  assign ready  = ~at_end | ~valid_out | ready_in;
  assign acc    = valid & ready;
  assign done   = acc & at_end;
  assign drain  = valid_out & ready_in;

  // Slots below cnt come from collection, slot cnt from i,
  // slots above cnt are zero padding (short groups only).
  always_comb begin
    o_nxt = '0;
    for (int k = 0; k < NUM - 1; k++) begin
      if (CW'(k) < cnt)
        o_nxt[k*BITS +: BITS] = slot[k];
      else if (CW'(k) == cnt)
        o_nxt[k*BITS +: BITS] = i;
    end
    if (cnt == CNT_MAX)
      o_nxt[(NUM-1)*BITS +: BITS] = i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      slot      <= '0;
      o         <= '0;
      valid_out <= 1'b0;
    end else begin
      if (acc)
        cnt <= done ? '0 : cnt + CW'(1);
      for (int k = 0; k < NUM - 1; k++) begin
        if (acc && !done && cnt == CW'(k))
          slot[k] <= i;
      end
      if (done) begin
        o         <= o_nxt;
        valid_out <= 1'b1;
      end else if (drain) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/adder_deser.md
# adder_deser

Stream-to-parallel feeder for the adder tree: accepts one `BITS`-wide operand per cycle over a valid/ready handshake and assembles `NUM` consecutive operands into one parallel group. The group is presented on a flattened bus with `valid_out` and is held until the consumer accepts it. The block sits upstream of an `adder` instance (`bits`/`num` matched), which turns a serial operand stream into the adder's parallel `i0..i{num-1}` inputs.

## Interface
- `BITS`, 16, operand width.
- `NUM`, 4, operands per group; legal range 2..64.

- `clk` input 1 clock; all state updates on rising edge.
- `reset` input 1 asynchronous, active-high reset.
- `valid` input 1 upstream operand valid.
- `i` input BITS upstream operand.
- `ready` output 1 upstream may transfer; beat accepted when `valid & ready`.
- `last` input 1 final operand of a short group; present only with `ADDER_DESER_LAST_EN`.
- `o` output NUM*BITS group; slot k at `o[k*BITS +: BITS]`, slot 0 = first operand received.
- `valid_out` output 1 group on `o` is valid.
- `ready_in` input 1 downstream accepts; group transfers when `valid_out & ready_in`.

## Operation
- State:
  - slot counter `cnt`, width `$clog2(NUM)`, range 0..NUM-1;
  - collection registers for slots 0..NUM-2;
  - output register `o` plus `valid_out`.
- Non-completing beat (`cnt < NUM-1`): the beat writes `i` into slot `cnt` and increments `cnt`.
- Completing beat (`cnt == NUM-1`):
  - loads `o` in one cycle with collection slots 0..NUM-2 and slot NUM-1 taken from `i`;
  - sets `valid_out=1` and sets `cnt=0`.
- `ready`:
  - 1 when `cnt != NUM-1`;
  - 1 when `valid_out == 0`;
  - 1 when `ready_in == 1`;
  - 0 otherwise.
  - The combinational path from `ready_in` to `ready` is intentional.
- Output drain: `valid_out` clears on `valid_out & ready_in` unless the same cycle carries a completing beat. In that case `o` reloads and `valid_out` stays 1.
- `o` holds its value whenever `valid_out & ~ready_in`. `o` does not change while `valid_out=0` except on a completing beat.
- Collection slots retain stale data after a group completes. Only slots written in the current group reach `o`, except for the padding defined under Configuration.
- No arithmetic is performed. Operands pass bit-exact and no sign handling is applied.

## Timing
- Reset values:
  - `ready=1`, `valid_out=0`, `o=0`, `cnt=0`;
  - collection registers = 0.
- Reset mid-group discards the partial group and any held output.
- Latency: completing beat accepted at cycle N gives `valid_out=1` and the new `o` at cycle N+1.
- Throughput: one operand per cycle sustained when `ready_in=1`, i.e. one group per NUM cycles.
- Backpressure:
  - While `valid_out & ~ready_in`, beats for slots 0..NUM-2 are still accepted.
  - The stall is only at the completing beat (`ready=0` at `cnt==NUM-1`).
- `valid` may drop between beats. Gaps do not reset `cnt`.
- Upstream must hold `i` and `valid` stable while `valid & ~ready`. The block samples nothing on non-accepted cycles.

## Configuration
- `ADDER_DESER_LAST_EN` defined:
  - Adds input `last`.
  - An accepted beat with `last=1` completes the group regardless of `cnt`: slot `cnt` gets `i`, slots `cnt+1..NUM-1` of `o` are forced to 0 (additive identity), and `cnt` returns to 0.
  - Such a beat is subject to the same `ready` rule as a completing beat, i.e. `ready = ~valid_out | ready_in` whenever `last` may complete.
  - `ready` therefore also depends on `valid & last`.
  - `last` on a beat that is already at `cnt == NUM-1` is equivalent to a normal completion.
- Undefined: no `last` port; groups are always exactly NUM operands.

## Test plan
- Reset, then stream 1,2,3,4 on consecutive cycles with `ready_in=1` (NUM=4). Required: `o = {16'd4,16'd3,16'd2,16'd1}` (slot 0 = 1) and `valid_out` high for exactly the one cycle after the 4th beat.
- Continuous stream 1..12 with `ready_in=1`. Required: three groups {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, `valid_out` pulsing every 4 cycles, `ready` constant 1.
- First group completes with `ready_in=0` for 6 cycles while beats 5..7 arrive. Required:
  - `o` holds {1,2,3,4};
  - beats 5,6,7 are accepted;
  - `ready=0` at the 8th beat until `ready_in` rises, then the 8th beat is accepted in that same cycle and `o` becomes {5,6,7,8} the next cycle with `valid_out` remaining 1.
- Assert `reset` after 2 beats (values 9,9), then send 1,2,3,4. Required: output group {1,2,3,4}, with no trace of the 9s.
- With `ADDER_DESER_LAST_EN`, send 7 then 8 with `last=1`. Required: `o = {0,0,8,7}` and `valid_out` one cycle later; the next group starts at slot 0.
- Hold `valid=0` for 3 cycles between beats 2 and 3 of a group. Required: the group still equals the 4 operands in order and `valid_out` follows the 4th beat by one cycle.
